control_multiply: RTL and testbench
===================================

// Module: control_multiply
// PURPOSE
//  Read-side sequencer for the inverse matrix store MxBinv.
//  It runs after the inverse writer pulses doneinvMxB, and computes C = A x inv(B) for N x N matrices.
//  It walks i, j and k, issues paired reads of MxA[i][k] and MxBinv[k][j], and drives MAC enables aligned to the returning data.
//  It writes each finished C[i][j] into MxC.
// PARAMETERS
//  N_LOG2   2   log2 of the matrix dimension (default gives a 4x4 matrix)
//  ADDR_W   4   address width, equal to 2*N_LOG2; address = {row, col}
//  RD_LAT   1   read latency of MxA/MxBinv in clocks (legal range 1..3)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous reset, active-high
//  start        in   1       one-cycle request; sampled only in IDLE (wire it to doneinvMxB)
//  reMxA        out  1       read enable for MxA
//  addrMxA      out  ADDR_W  MxA address {i,k}
//  reMxBinv     out  1       read enable for MxBinv
//  addrMxBinv   out  ADDR_W  MxBinv address {k,j}
//  clrAcc       out  1       load the accumulator with the product, discarding the old sum (first term)
//  enAcc        out  1       accumulate the product of the data returned this cycle
//  weMxC        out  1       write the accumulator into MxC
//  addrMxC      out  ADDR_W  MxC address {i,j}
//  busy         out  1       high in every state except IDLE
//  done         out  1       one-cycle pulse when the final MxC write has been issued
// BEHAVIOUR
//  Reset value: every output is 0; addresses are driven to 0, never to z. FSM = IDLE; i = j = k = 0.
//  FSM states:
//   IDLE  -> ISSUE when start = 1.
//   ISSUE -> DRAIN after the read with i = j = k = N-1 has been issued.
//   DRAIN -> DONE when the last weMxC has been issued.
//   DONE  -> IDLE unconditionally after 1 cycle.
//  ISSUE:
//   reMxA and reMxBinv are both high for every cycle.
//   k increments every cycle; on k wrap, j increments; on j wrap, i increments.
//   Issue order is row-major over (i,j), with k innermost.
//   Total issue cycles: N^3 (64 for the default).
//  Data alignment:
//   enAcc = reMx* delayed by RD_LAT.
//   clrAcc = (issued k == 0) delayed by RD_LAT.
//  Write-back:
//   weMxC = (issued k == N-1) delayed by RD_LAT+1.
//   addrMxC carries the matching {i,j}, delayed by the same amount.
//   weMxC is never concurrent with clrAcc for the same element.
//  Latency:
//   First read is issued on the cycle after start is sampled.
//   First weMxC occurs N+RD_LAT cycles after the first read.
//   done occurs 1 cycle after the final weMxC.
//   start-to-done = N^3 + RD_LAT + 2 cycles (67 for the defaults).
//  Boundary conditions:
//   start while busy (ISSUE, DRAIN or DONE): ignored; no restart and no queuing.
//   start held high continuously: a new pass starts in the first IDLE cycle after DONE.
//   rst mid-operation: immediately clears all outputs and the delay pipelines; returns to IDLE; the partial MxC contents are undefined.
//   Counter wrap at i = j = k = N-1: no further reads; addresses hold their last value, with reads deasserted.
//   Outputs are registered and glitch-free; no combinational path from start to any output.
// CONFIGURATION
//  Macro: MXMUL_COFACTOR_SIGN_EN
//   Defined:
//    Adds output port signB (1 bit), delayed with enAcc.
//    signB = addrMxBinv[0] XOR addrMxBinv[N_LOG2] (checkerboard parity) for the data returning in that cycle.
//    The MAC negates the product when signB = 1, so MxBinv may hold unsigned cofactor magnitudes.
//    signB resets to 0.
//   Not defined:
//    The port does not exist.
//    MxBinv is assumed to already hold signed values.
//    No other behaviour changes.
// TESTING
//  T1 Reset: assert rst mid-cycle with clk stopped -> all outputs 0 and busy = 0 without any clock edge.
//  T2 Full pass (N=4, RD_LAT=1): pulse start at cycle 0 ->
//     - reads are issued on cycles 1..64;
//     - addrMxA sequence starts 0,1,2,3,0,1,2,3; addrMxBinv starts 0,4,8,12,1,5,9,13;
//     - weMxC is high on cycles 6,10,...,66, with addrMxC = 0..15;
//     - done is high on cycle 67.
//  T3 Arithmetic: A = identity and MxBinv[r][c] = 16*r + c -> MxC equals MxBinv exactly (scoreboard compares all 16 entries).
//  T4 Ignored start: pulse start again at cycles 10 and 67 -> single done, at cycle 67; no second pass.
//  T5 Reset mid-run: assert rst at cycle 30 and start again at cycle 40 ->
//     - no weMxC occurs between the reset and the restart;
//     - a full pass completes with done at cycle 107.
//  T6 With MXMUL_COFACTOR_SIGN_EN defined: signB, observed with enAcc, reads 0,1,0,1 for j = 0 and 1,0,1,0 for j = 1.

Source files
------------

// File: rtl/control_multiply.sv
// control_multiply: read-side sequencer computing C = A x inv(B) for N x N matrices.
// Walks i, j and k with k innermost, and issues paired reads of MxA[i][k] and
// MxBinv[k][j]. It drives the MAC clear/accumulate strobes so they line up with
// the returning read data, then writes each finished C[i][j] into MxC.
// Optional feature macro: MXMUL_COFACTOR_SIGN_EN adds the signB output. signB is
// the checkerboard sign of the MxBinv element whose data returns in that cycle.
module control_multiply #(
  parameter int N_LOG2 = 2,
  parameter int ADDR_W = 2 * N_LOG2,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              reMxA,
  output logic [ADDR_W-1:0] addrMxA,
  output logic              reMxBinv,
  output logic [ADDR_W-1:0] addrMxBinv,
  output logic              clrAcc,
  output logic              enAcc,
  output logic              weMxC,
  output logic [ADDR_W-1:0] addrMxC,
  output logic              busy,
  output logic              done
`ifdef MXMUL_COFACTOR_SIGN_EN
  ,
  output logic              signB
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N_LOG2-1:0] IDX_MAX  = {N_LOG2{1'b1}};
  localparam logic [N_LOG2-1:0] IDX_ZERO = {N_LOG2{1'b0}};

  state_t              state_r;
  state_t              state_s;
  logic [N_LOG2-1:0]   i_r;
  logic [N_LOG2-1:0]   j_r;
  logic [N_LOG2-1:0]   k_r;
  logic                rd_s;
  logic                clr_s;
  logic                wb_s;
  logic                last_s;
  logic                re_r;
  logic                busy_r;
  logic                done_r;
  logic [RD_LAT-1:0]   en_pipe_r;
  logic [RD_LAT-1:0]   clr_pipe_r;
  logic [RD_LAT:0]     we_pipe_r;
  logic [RD_LAT:0]     last_pipe_r;
  logic [2*N_LOG2-1:0] cij_pipe_r [RD_LAT+1];

`ifdef MXMUL_COFACTOR_SIGN_EN
  logic [RD_LAT-1:0]   sgn_pipe_r;

  // Checkerboard sign of an MxBinv address {row, col}: odd row+col means negative.
  function automatic logic checkerboard_sign(input logic [ADDR_W-1:0] addr);
    return addr[0] ^ addr[N_LOG2];
  endfunction
`endif

  // State register plus the registered status/read-enable outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      re_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      re_r    <= (state_s == ISSUE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Next-state logic: start is honoured only in IDLE, so it is never queued.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (last_s) state_s = DRAIN; else state_s = ISSUE;
      DRAIN:   if (last_pipe_r[RD_LAT]) state_s = DONE; else state_s = DRAIN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Issue-stage decode: which reads are going out this cycle and what they mark.
  always_comb begin
    rd_s   = (state_r == ISSUE);
    clr_s  = rd_s && (k_r == IDX_ZERO);
    wb_s   = rd_s && (k_r == IDX_MAX);
    last_s = wb_s && (i_r == IDX_MAX) && (j_r == IDX_MAX);
  end

  // Index counters: k innermost, then j, then i; they hold at the final element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_r <= IDX_ZERO;
      j_r <= IDX_ZERO;
      k_r <= IDX_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            i_r <= IDX_ZERO;
            j_r <= IDX_ZERO;
            k_r <= IDX_ZERO;
          end
        end
        ISSUE: begin
          if (!last_s) begin
            k_r <= k_r + N_LOG2'(1);
            if (k_r == IDX_MAX) begin
              j_r <= j_r + N_LOG2'(1);
              if (j_r == IDX_MAX) begin
                i_r <= i_r + N_LOG2'(1);
              end
            end
          end
        end
        default: begin
          i_r <= i_r;
          j_r <= j_r;
          k_r <= k_r;
        end
      endcase
    end
  end

  // Delay lines aligning MAC strobes with read data and write-back with the finished sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe_r   <= '0;
      clr_pipe_r  <= '0;
      we_pipe_r   <= '0;
      last_pipe_r <= '0;
      for (int n = 0; n <= RD_LAT; n++) begin
        cij_pipe_r[n] <= '0;
      end
    end else begin
      en_pipe_r[0]   <= rd_s;
      clr_pipe_r[0]  <= clr_s;
      we_pipe_r[0]   <= wb_s;
      last_pipe_r[0] <= last_s;
      cij_pipe_r[0]  <= {i_r, j_r};
      for (int n = 1; n < RD_LAT; n++) begin
        en_pipe_r[n]  <= en_pipe_r[n-1];
        clr_pipe_r[n] <= clr_pipe_r[n-1];
      end
      for (int n = 1; n <= RD_LAT; n++) begin
        we_pipe_r[n]   <= we_pipe_r[n-1];
        last_pipe_r[n] <= last_pipe_r[n-1];
        cij_pipe_r[n]  <= cij_pipe_r[n-1];
      end
    end
  end

`ifdef MXMUL_COFACTOR_SIGN_EN
  // Sign of the MxBinv element travels alongside enAcc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_pipe_r <= '0;
    end else begin
      sgn_pipe_r[0] <= rd_s && checkerboard_sign({k_r, j_r});
      for (int n = 1; n < RD_LAT; n++) begin
        sgn_pipe_r[n] <= sgn_pipe_r[n-1];
      end
    end
  end

  assign signB = sgn_pipe_r[RD_LAT-1];
`endif

  assign reMxA      = re_r;
  assign reMxBinv   = re_r;
  assign addrMxA    = {i_r, k_r};
  assign addrMxBinv = {k_r, j_r};
  assign enAcc      = en_pipe_r[RD_LAT-1];
  assign clrAcc     = clr_pipe_r[RD_LAT-1];
  assign weMxC      = we_pipe_r[RD_LAT];
  assign addrMxC    = cij_pipe_r[RD_LAT];
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_control_multiply.sv
// Testbench for control_multiply: time-indexed reference model of a pass,
// emulated MxA/MxBinv memories plus a MAC, and arithmetic checks of MxC.
module tb_control_multiply;
  localparam int N_LOG2 = 2;
  localparam int N      = 1 << N_LOG2;
  localparam int ADDR_W = 2 * N_LOG2;
  localparam int RD_LAT = 1;
  localparam int NE     = N * N;
  localparam int NR     = N * N * N;
  localparam int T_WE0  = N + RD_LAT + 1;
  localparam int T_DONE = NR + RD_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  bit   clk_run = 1'b0;
  bit   mon_on = 1'b0;
  logic reMxA, reMxBinv, clrAcc, enAcc, weMxC, busy, done;
  logic [ADDR_W-1:0] addrMxA, addrMxBinv, addrMxC;
`ifdef MXMUL_COFACTOR_SIGN_EN
  logic signB;
`endif

  control_multiply #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .reMxA(reMxA), .addrMxA(addrMxA),
    .reMxBinv(reMxBinv), .addrMxBinv(addrMxBinv),
    .clrAcc(clrAcc), .enAcc(enAcc), .weMxC(weMxC), .addrMxC(addrMxC),
    .busy(busy), .done(done)
`ifdef MXMUL_COFACTOR_SIGN_EN
    , .signB(signB)
`endif
  );

  always #5 if (clk_run) clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int we_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: a pass is fully described by the cycles elapsed since start was accepted.
  bit m_act = 1'b0;
  int m_t = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (m_act) begin
      if (m_t == T_DONE) m_act <= 1'b0;
      else m_t <= m_t + 1;
    end else if (start) begin
      m_act <= 1'b1;
      m_t   <= 1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      bit e_re, e_en, e_clr, e_we, e_done;
      int n, r;
      e_re   = m_act && (m_t <= NR);
      e_en   = m_act && (m_t >= 1 + RD_LAT) && (m_t <= NR + RD_LAT);
      r      = m_t - 1 - RD_LAT;
      e_clr  = e_en && (r % N == 0);
      e_we   = m_act && (m_t >= T_WE0) && (m_t <= NR + RD_LAT + 1) && ((m_t - T_WE0) % N == 0);
      e_done = m_act && (m_t == T_DONE);
      check("busy", busy, m_act);
      check("done", done, e_done);
      check("reMxA", reMxA, e_re);
      check("reMxBinv", reMxBinv, e_re);
      check("enAcc", enAcc, e_en);
      check("clrAcc", clrAcc, e_clr);
      check("weMxC", weMxC, e_we);
      if (e_re) begin
        n = m_t - 1;
        check("addrMxA", addrMxA, (n / NE) * N + n % N);
        check("addrMxBinv", addrMxBinv, (n % N) * N + (n / N) % N);
      end
      if (e_we) check("addrMxC", addrMxC, (m_t - T_WE0) / N);
`ifdef MXMUL_COFACTOR_SIGN_EN
      if (e_en) check("signB", signB, ((r % N) ^ ((r / N) % N)) & 1);
`endif
      if (done === 1'b1) done_cnt++;
      if (weMxC === 1'b1) we_cnt++;
    end
  end

  // Emulated memories with RD_LAT read latency feeding a MAC that writes MxC.
  int memA [NE];
  int memB [NE];
  int memC [NE];
  int pa [RD_LAT];
  int pb [RD_LAT];
  int acc = 0;
  always @(posedge clk) begin
    int prod;
    for (int n = RD_LAT - 1; n > 0; n--) begin
      pa[n] <= pa[n-1];
      pb[n] <= pb[n-1];
    end
    pa[0] <= memA[addrMxA];
    pb[0] <= memB[addrMxBinv];
    prod = pa[RD_LAT-1] * pb[RD_LAT-1];
`ifdef MXMUL_COFACTOR_SIGN_EN
    if (signB) prod = -prod;
`endif
    if (weMxC) memC[addrMxC] <= acc;
    if (clrAcc) acc <= prod;
    else if (enAcc) acc <= acc + prod;
  end

  function automatic int exp_c(input int e);
    int s = 0;
    int i = e / N;
    int j = e % N;
    for (int k = 0; k < N; k++) begin
`ifdef MXMUL_COFACTOR_SIGN_EN
      if (((k ^ j) & 1) != 0) s -= memA[i*N+k] * memB[k*N+j];
      else s += memA[i*N+k] * memB[k*N+j];
`else
      s += memA[i*N+k] * memB[k*N+j];
`endif
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_done(input int c0, input int exp, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 400);
    if (done === 1'b1) check(nm, cyc - c0, exp);
    else check(nm, 32'hFFFF_FFFF, exp);
  endtask

  task automatic fill_random();
    for (int e = 0; e < NE; e++) begin
      memA[e] = int'($urandom_range(0, 255));
      memB[e] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic check_c(input string nm);
    for (int e = 0; e < NE; e++) check(nm, memC[e], exp_c(e));
  endtask

  int tbl_a [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int tbl_b [8] = '{0, 4, 8, 12, 1, 5, 9, 13};
`ifdef MXMUL_COFACTOR_SIGN_EN
  int tbl_s [8] = '{0, 1, 0, 1, 1, 0, 1, 0};
`endif

  initial begin
    int c0, d0, w0;
    // Reset with the clock stopped.
    #3 rst = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_reMxA", reMxA, 0);
    check("rst_weMxC", weMxC, 0);
    check("rst_enAcc", enAcc, 0);
    check("rst_addrMxA", addrMxA, 0);
    check("rst_addrMxBinv", addrMxBinv, 0);
    check("rst_addrMxC", addrMxC, 0);
    #2 rst = 1'b0;
    mon_on  = 1'b1;
    clk_run = 1'b1;
    repeat (3) tick();

    // Identity A with MxBinv[r][c] = 16r + c, plus ignored start pulses.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        memA[r*N+c] = (r == c) ? 1 : 0;
        memB[r*N+c] = 16 * r + c;
      end
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      if (t <= 8) begin
        check("seq_addrMxA", addrMxA, tbl_a[t-1]);
        check("seq_addrMxBinv", addrMxBinv, tbl_b[t-1]);
      end
`ifdef MXMUL_COFACTOR_SIGN_EN
      if (t >= 2) check("seq_signB", signB, tbl_s[t-2]);
`endif
    end
    goto(c0 + 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    d0 = done_cnt;
    wait_done(c0, 67, "done_cycle");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("single_done", done_cnt - d0, 1);
    check("idle_after_pass", busy, 0);
    check_c("C_identity");
`ifndef MXMUL_COFACTOR_SIGN_EN
    for (int e = 0; e < NE; e++) check("C_eq_Binv", memC[e], 16 * (e / N) + (e % N));
`endif

    // Reset mid-run, then restart.
    fill_random();
    tick();
    c0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    goto(c0 + 30);
    rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    w0 = we_cnt;
    goto(c0 + 40);
    check("no_we_after_rst", we_cnt - w0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(c0, 107, "done_after_rst");
    tick();
    check_c("C_after_rst");

    // Start held high: back-to-back passes separated by one IDLE cycle.
    repeat (2) tick();
    c0 = cyc;
    start = 1'b1;
    wait_done(c0, T_DONE, "held_first_done");
    wait_done(c0, 2 * T_DONE + 1, "held_second_done");
    start = 1'b0;
    tick();
    check_c("C_held");

    // Randomized passes with random gaps and start noise while busy.
    for (int p = 0; p < 4; p++) begin
      fill_random();
      repeat ($urandom_range(1, 5)) tick();
      c0 = cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int q = 0; q < 40; q++) begin
        start = ($urandom_range(0, 5) == 0);
        tick();
      end
      start = 1'b0;
      wait_done(c0, T_DONE, "rand_done");
      tick();
      check_c("C_random");
    end

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
